// File: rtl/mips16_pkg.sv
// Shared MIPS16 pipeline definitions: datapath widths and the
// execute-result buffer occupancy encoding.
package mips16_pkg;

    localparam int DATA_W = 32;
    localparam int CC_W   = 6;
    localparam int RD_W   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/ex_result_buf.sv
// Two-entry (main + skid) buffer between the ALU and write-back stages.
// Define EX_RESULT_BUF_STATS_EN to build the 16-bit retired-transfer counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on registered state, never on out_ready.
// Once out_valid is high, the presented fields hold until out_ready takes them.
module ex_result_buf
    import mips16_pkg::*;
#(
    parameter int DATA_W = mips16_pkg::DATA_W,
    parameter int CC_W   = mips16_pkg::CC_W,
    parameter int RD_W   = mips16_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [CC_W-1:0]   cond_code,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic              wr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CC_W-1:0]   out_cc,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en,
    output logic [CC_W-1:0]   cc_reg,
    output logic [15:0]       xfer_cnt,
    output logic [1:0]        state_dbg
);

    buf_state_t        state_q;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CC_W-1:0]   main_cc,   skid_cc;
    logic [RD_W-1:0]   main_rd,   skid_rd;
    logic              main_wr,   skid_wr;
    logic              in_xfer, out_xfer;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign out_data  = main_data;
    assign out_cc    = main_cc;
    assign out_rd    = main_rd;
    assign out_wr_en = main_wr;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            main_data <= '0;
            main_cc   <= '0;
            main_rd   <= '0;
            main_wr   <= 1'b0;
            skid_data <= '0;
            skid_cc   <= '0;
            skid_rd   <= '0;
            skid_wr   <= 1'b0;
            cc_reg    <= '0;
        end else begin
            // A retirement in a flush cycle is still architecturally visible.
            if (out_xfer)
                cc_reg <= main_cc;

            if (flush) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_data <= alu_out;
                            main_cc   <= cond_code;
                            main_rd   <= rd_addr;
                            main_wr   <= wr_en;
                            state_q   <= ONE;
                        end
                    end
                    ONE: begin
                        case ({in_xfer, out_xfer})
                            2'b10: begin
                                skid_data <= alu_out;
                                skid_cc   <= cond_code;
                                skid_rd   <= rd_addr;
                                skid_wr   <= wr_en;
                                state_q   <= TWO;
                            end
                            2'b01: state_q <= EMPTY;
                            2'b11: begin
                                main_data <= alu_out;
                                main_cc   <= cond_code;
                                main_rd   <= rd_addr;
                                main_wr   <= wr_en;
                            end
                            default: ;
                        endcase
                    end
                    TWO: begin
                        if (out_xfer) begin
                            main_data <= skid_data;
                            main_cc   <= skid_cc;
                            main_rd   <= skid_rd;
                            main_wr   <= skid_wr;
                            state_q   <= ONE;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

`ifdef EX_RESULT_BUF_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (out_xfer)
            cnt_q <= cnt_q + 16'd1;
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_result_buf.sv
// Directed bench for ex_result_buf: reset, single entry, backpressure,
// streaming, flush, counter wrap and asynchronous reset.
module tb_ex_result_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [5:0]  cond_code;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_cc;
    logic [3:0]  out_rd;
    logic        out_wr_en;
    logic [5:0]  cc_reg;
    logic [15:0] xfer_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    ex_result_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .cond_code (cond_code),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cc    (out_cc),
        .out_rd    (out_rd),
        .out_wr_en (out_wr_en),
        .cc_reg    (cc_reg),
        .xfer_cnt  (xfer_cnt),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] d, input logic [5:0] cc,
                            input logic [3:0] rd, input logic we);
        in_valid  = v;
        alu_out   = d;
        cond_code = cc;
        rd_addr   = rd;
        wr_en     = we;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef EX_RESULT_BUF_STATS_EN
        return pops[15:0];
`else
        return 16'd0;
`endif
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);

        // Reset then idle
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd_cc", {22'b0, out_rd, out_cc}, 32'd0);
        check("rst_out_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("rst_cc_reg", {26'b0, cc_reg}, 32'd0);
        check("rst_xfer_cnt", {16'b0, xfer_cnt}, 32'd0);
        check("rst_state", {30'b0, state_dbg}, {30'b0, S_EMPTY});
        rst_n = 1'b1;
        step();
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Single entry
        out_ready = 1'b1;
        drive_in(1'b1, 32'h12, 6'b000000, 4'd3, 1'b1);
        step();
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_data", out_data, 32'h12);
        check("single_rd", {28'b0, out_rd}, 32'd3);
        check("single_wr_en", {31'b0, out_wr_en}, 32'd1);
        step();
        pops++;
        check("single_drained", {31'b0, out_valid}, 32'd0);
        check("single_cc_reg", {26'b0, cc_reg}, 32'd0);
        check("single_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt()});

        // Backpressure
        out_ready = 1'b0;
        drive_in(1'b1, 32'h12, 6'h15, 4'd1, 1'b1);
        step();
        check("bp_one_state", {30'b0, state_dbg}, {30'b0, S_ONE});
        drive_in(1'b1, 32'h0E, 6'h2A, 4'd2, 1'b0);
        step();
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        check("bp_two_state", {30'b0, state_dbg}, {30'b0, S_TWO});
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_hold_data", out_data, 32'h12);
        step();
        check("bp_stable_data", out_data, 32'h12);
        check("bp_stable_cc", {26'b0, out_cc}, 32'h15);
        check("bp_stable_valid", {31'b0, out_valid}, 32'd1);
        check("bp_cc_reg_hold", {26'b0, cc_reg}, 32'd0);
        out_ready = 1'b1;
        step();
        pops++;
        check("bp_pop1_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_pop1_data", out_data, 32'h0E);
        check("bp_pop1_rd", {28'b0, out_rd}, 32'd2);
        check("bp_pop1_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("bp_pop1_cc_reg", {26'b0, cc_reg}, 32'h15);
        step();
        pops++;
        check("bp_pop2_empty", {31'b0, out_valid}, 32'd0);
        check("bp_pop2_cc_reg", {26'b0, cc_reg}, 32'h2A);
        check("bp_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt()});

        // Streaming: one transfer per cycle, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 32'h10 + 32'(i * 2), 6'(i), 4'(i), 1'b1);
            exp_q.push_back(32'h10 + 32'(i * 2));
            step();
            if (i > 0) pops++;
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
            check("stream_data", out_data, exp_q.pop_front());
        end
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        step();
        pops++;
        check("stream_drained", {31'b0, out_valid}, 32'd0);
        check("stream_cc_reg", {26'b0, cc_reg}, 32'd7);
        check("stream_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt()});

        // Flush in TWO without a pop: cc_reg unchanged, input dropped
        out_ready = 1'b0;
        drive_in(1'b1, 32'h21, 6'h03, 4'd5, 1'b1);
        step();
        drive_in(1'b1, 32'h22, 6'h04, 4'd6, 1'b1);
        step();
        check("flush_pre_two", {30'b0, state_dbg}, {30'b0, S_TWO});
        flush = 1'b1;
        drive_in(1'b1, 32'h99, 6'h3F, 4'd9, 1'b1);
        step();
        flush = 1'b0;
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        check("flush_state", {30'b0, state_dbg}, {30'b0, S_EMPTY});
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_cc_reg", {26'b0, cc_reg}, 32'd7);
        step();
        check("flush_dropped", {30'b0, state_dbg}, {30'b0, S_EMPTY});
        check("flush_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt()});

        // Flush in TWO with a simultaneous pop: cc_reg and counter still update
        drive_in(1'b1, 32'h31, 6'h11, 4'd7, 1'b1);
        step();
        drive_in(1'b1, 32'h32, 6'h12, 4'd8, 1'b1);
        step();
        out_ready = 1'b1;
        flush     = 1'b1;
        drive_in(1'b1, 32'h99, 6'h3F, 4'd9, 1'b1);
        step();
        pops++;
        flush = 1'b0;
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        check("flushpop_state", {30'b0, state_dbg}, {30'b0, S_EMPTY});
        check("flushpop_cc_reg", {26'b0, cc_reg}, 32'h11);
        check("flushpop_xfer_cnt", {16'b0, xfer_cnt}, {16'b0, exp_cnt()});

        // Counter wrap: stream up to 0xFFFF retirements, then one more
        begin
            int n;
            n = 65535 - pops;
            for (int i = 0; i < n; i++) begin
                drive_in(1'b1, 32'(i), 6'(i), 4'(i), 1'b0);
                step();
            end
            drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
            step();
            pops += n;
        end
        check("wrap_ffff", {16'b0, xfer_cnt}, {16'b0, exp_cnt()});
        drive_in(1'b1, 32'hABCD, 6'h2C, 4'd4, 1'b1);
        step();
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        step();
        pops++;
        check("wrap_zero", {16'b0, xfer_cnt}, 32'd0);
        check("wrap_cc_reg", {26'b0, cc_reg}, 32'h2C);

        // Asynchronous reset while in TWO
        out_ready = 1'b0;
        drive_in(1'b1, 32'h41, 6'h21, 4'd1, 1'b1);
        step();
        drive_in(1'b1, 32'h42, 6'h22, 4'd2, 1'b1);
        step();
        drive_in(1'b0, 32'h0, 6'h0, 4'h0, 1'b0);
        check("arst_pre_two", {30'b0, state_dbg}, {30'b0, S_TWO});
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", {30'b0, state_dbg}, {30'b0, S_EMPTY});
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_out_data", out_data, 32'd0);
        check("arst_out_fields", {21'b0, out_wr_en, out_rd, out_cc}, 32'd0);
        check("arst_cc_reg", {26'b0, cc_reg}, 32'd0);
        check("arst_xfer_cnt", {16'b0, xfer_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_release_ready", {31'b0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
